dot_row_sched: RTL and testbench

- Sequencer that runs a matrix-vector product on one shared 16-lane Q4.11 dot-product PE (256-bit vector operands, 16-bit result, asserts finish when done).
- Latches an activation vector at start, then for each row: fetches the weight row from a 1-cycle-latency read port, pulses the PE reset, waits for finish, and writes the 16-bit result out over a valid/ready handshake.
- Sits between the layer controller (start/done) and the PE/weight buffer.

---
 rtl/dot_row_sched.sv | 202 ++++++++++++++++++++
 tb/tb_dot_row_sched.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dot_row_sched.sv
// dot_row_sched
// -------------
// Runs a matrix-vector product on a single shared 16-lane Q4.11 dot-product
// PE. The activation vector is latched when start is accepted. Then, for each
// weight row, the block:
//   1. reads the row from a 1-cycle-latency weight port,
//   2. releases the PE reset,
//   3. waits for pe_finish,
//   4. emits the 16-bit result on a valid/ready handshake.
//
// Build option:
//   DOT_ROW_SCHED_RELU_EN - when defined, negative PE results are written
//                           out as zero (ReLU). When undefined, results pass
//                           through unmodified.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   start                launch request (only honoured in IDLE)
//   num_rows             rows to process, clamped to 2**ROW_AW
//   in_vec               activation vector, latched with start
//   busy                 high while a job is in progress (through DONE)
//   done                 one-cycle completion pulse
//   w_rd_en              weight read strobe
//   w_rd_addr            weight row index
//   w_rd_data            weight row, valid the cycle after w_rd_en
//   pe_rst               PE synchronous reset; low only while the PE runs
//   pe_vec_a, pe_vec_b   registered PE operands
//   pe_dot, pe_finish    PE result and completion level
//   out_valid, out_ready result handshake
//   out_addr, out_data   row index and result of the current output

module dot_row_sched #(
    parameter int VEC_W  = 256,
    parameter int DATA_W = 16,
    parameter int ROW_AW = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ROW_AW:0]   num_rows,
    input  logic [VEC_W-1:0]  in_vec,
    output logic              busy,
    output logic              done,
    output logic              w_rd_en,
    output logic [ROW_AW-1:0] w_rd_addr,
    input  logic [VEC_W-1:0]  w_rd_data,
    output logic              pe_rst,
    output logic [VEC_W-1:0]  pe_vec_a,
    output logic [VEC_W-1:0]  pe_vec_b,
    input  logic [DATA_W-1:0] pe_dot,
    input  logic              pe_finish,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ROW_AW-1:0] out_addr,
    output logic [DATA_W-1:0] out_data
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        RUN,
        WRITE,
        DONE
    } state_t;

    // Row count and row index are one bit wider than the address, so that a
    // full 64-row job can terminate on row+1 == count without wrapping.
    localparam logic [ROW_AW:0] MAX_ROWS = {1'b1, {ROW_AW{1'b0}}};

    state_t            state;
    state_t            state_nx;
    logic [ROW_AW:0]   row;
    logic [ROW_AW:0]   count;
    logic [ROW_AW:0]   rows_clamped;
    logic [ROW_AW:0]   row_inc;
    logic              last_row;
    logic [DATA_W-1:0] result_sel;

    always_comb begin
        rows_clamped = (num_rows > MAX_ROWS) ? MAX_ROWS : num_rows;
        row_inc      = row + 1'b1;
        last_row     = (row_inc == count);
    end

`ifdef DOT_ROW_SCHED_RELU_EN
    always_comb begin
        result_sel = pe_dot[DATA_W-1] ? '0 : pe_dot;
    end
`else
    always_comb begin
        result_sel = pe_dot;
    end
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = (rows_clamped == '0) ? DONE : FETCH;
                end
            end
            FETCH: state_nx = LOAD;
            LOAD:  state_nx = RUN;
            RUN: begin
                if (pe_finish) begin
                    state_nx = WRITE;
                end
            end
            WRITE: begin
                if (out_ready) begin
                    state_nx = last_row ? DONE : FETCH;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs decoded from state. All of them are driven by the state
    // register, so they are glitch-free.
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        w_rd_en   = 1'b0;
        out_valid = 1'b0;
        pe_rst    = 1'b1;
        w_rd_addr = row[ROW_AW-1:0];
        case (state)
            IDLE: ;
            FETCH: begin
                busy    = 1'b1;
                w_rd_en = 1'b1;
            end
            LOAD: begin
                busy = 1'b1;
            end
            RUN: begin
                busy   = 1'b1;
                pe_rst = 1'b0;
            end
            WRITE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            row      <= '0;
            count    <= '0;
            pe_vec_a <= '0;
            pe_vec_b <= '0;
            out_addr <= '0;
            out_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        pe_vec_a <= in_vec;
                        count    <= rows_clamped;
                        row      <= '0;
                    end
                end
                LOAD: begin
                    pe_vec_b <= w_rd_data;
                end
                RUN: begin
                    if (pe_finish) begin
                        out_data <= result_sel;
                        out_addr <= row[ROW_AW-1:0];
                    end
                end
                WRITE: begin
                    if (out_ready) begin
                        row <= row_inc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dot_row_sched.sv
// Testbench for dot_row_sched. It models the weight RAM and the PE, checks
// results against a reference dot-product model and checks the timing of the
// control outputs.
module tb_dot_row_sched;

    localparam int VEC_W  = 256;
    localparam int DATA_W = 16;
    localparam int ROW_AW = 6;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [ROW_AW:0]   num_rows = '0;
    logic [VEC_W-1:0]  in_vec = '0;
    logic              busy, done, w_rd_en, pe_rst, pe_finish, out_valid;
    logic              out_ready = 1'b1;
    logic [ROW_AW-1:0] w_rd_addr, out_addr;
    logic [VEC_W-1:0]  w_rd_data, pe_vec_a, pe_vec_b;
    logic [DATA_W-1:0] pe_dot, out_data;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    dot_row_sched #(.VEC_W(VEC_W), .DATA_W(DATA_W), .ROW_AW(ROW_AW)) dut (
        .clk(clk), .rst(rst), .start(start), .num_rows(num_rows), .in_vec(in_vec),
        .busy(busy), .done(done), .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr),
        .w_rd_data(w_rd_data), .pe_rst(pe_rst), .pe_vec_a(pe_vec_a),
        .pe_vec_b(pe_vec_b), .pe_dot(pe_dot), .pe_finish(pe_finish),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
        .out_data(out_data)
    );

    // ---------------- reference arithmetic ----------------
    // Q4.11 dot product: sum of the 16 signed lane products, shifted back by
    // 11 fraction bits, wrapped to 16 bits.
    function automatic logic [15:0] dot_ref(input logic [255:0] a, input logic [255:0] b);
        longint acc;
        acc = 0;
        for (int i = 0; i < 16; i++)
            acc += longint'($signed(a[16*i +: 16])) * longint'($signed(b[16*i +: 16]));
        acc = acc >>> 11;
        return acc[15:0];
    endfunction

    function automatic logic [15:0] ref_result(input logic [255:0] a, input logic [255:0] b);
        logic [15:0] r;
        r = dot_ref(a, b);
`ifdef DOT_ROW_SCHED_RELU_EN
        if (r[15]) r = '0;
`endif
        return r;
    endfunction

    function automatic logic [255:0] lanes(input logic [15:0] v);
        return {16{v}};
    endfunction

    function automatic logic [255:0] rand_vec();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[32*k +: 32] = $urandom;
        return v;
    endfunction

    // ---------------- environment models ----------------
    logic [255:0] w_mem [64];
    int unsigned  pe_cnt = 0;

    always @(posedge clk) begin
        if (w_rd_en) w_rd_data <= w_mem[w_rd_addr];
        else         w_rd_data <= {8{$urandom}};
    end

    // PE: finish rises so that it is seen in the 19th cycle with pe_rst low.
    always @(posedge clk) begin
        if (pe_rst)          pe_cnt <= 0;
        else if (pe_cnt < 31) pe_cnt <= pe_cnt + 1;
    end
    assign pe_finish = (pe_cnt >= 18);
    assign pe_dot    = pe_finish ? dot_ref(pe_vec_a, pe_vec_b) : 16'hDEAD;

    // ---------------- event monitor (logs only) ----------------
    int unsigned cyc = 0, rd_cnt = 0, done_cnt = 0, valid_cnt = 0;
    int unsigned rd_in_wr = 0, stall_viol = 0, win = 0;
    bit          prev_stall = 1'b0;
    logic [5:0]  pa;
    logic [15:0] pd;
    logic [5:0]  wr_addr_q[$];
    logic [15:0] wr_data_q[$];
    logic [5:0]  rd_addr_q[$];
    int unsigned rd_cyc_q[$], done_cyc_q[$], rst_win_q[$];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (w_rd_en) begin
            rd_cnt <= rd_cnt + 1;
            rd_addr_q.push_back(w_rd_addr);
            rd_cyc_q.push_back(cyc);
        end
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc_q.push_back(cyc);
        end
        if (out_valid) valid_cnt <= valid_cnt + 1;
        if (out_valid && w_rd_en) rd_in_wr <= rd_in_wr + 1;
        if (out_valid && out_ready) begin
            wr_addr_q.push_back(out_addr);
            wr_data_q.push_back(out_data);
        end
        if (prev_stall && out_valid && (out_addr !== pa || out_data !== pd))
            stall_viol <= stall_viol + 1;
        prev_stall <= out_valid && !out_ready;
        pa <= out_addr;
        pd <= out_data;
        if (!pe_rst) win <= win + 1;
        else if (win != 0) begin
            rst_win_q.push_back(win);
            win <= 0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Launches one job from IDLE and waits (bounded) for done. lat is the
    // count of cycles from the accepting edge to the done cycle.
    task automatic run_job(input int n, input logic [255:0] vec, input int stall,
                           input int poke_at, output int lat, output bit busy_ok,
                           output bit timeout);
        int wait_cnt;
        wait_cnt  = 0;
        start     = 1'b1;
        num_rows  = n[6:0];
        in_vec    = vec;
        out_ready = (stall == 0);
        step();
        start    = 1'b0;
        num_rows = 7'($urandom);
        in_vec   = rand_vec();
        lat      = 0;
        busy_ok  = 1'b1;
        timeout  = 1'b1;
        for (int i = 1; i <= 5000; i++) begin
            if (out_valid) begin
                if (wait_cnt < stall) begin
                    out_ready = 1'b0;
                    wait_cnt++;
                end else begin
                    out_ready = 1'b1;
                end
            end else begin
                wait_cnt  = 0;
                out_ready = (stall == 0);
            end
            start = (i == poke_at);
            if (start) num_rows = 7'd1;
            if (!busy) busy_ok = 1'b0;
            if (done) begin
                lat     = i;
                timeout = 1'b0;
                break;
            end
            step();
        end
        start     = 1'b0;
        out_ready = 1'b1;
        step();
        if (busy) busy_ok = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int unsigned brd;
        rst = 1'b1;
        start = 1'b0;
        repeat (3) step();
        checks++; if (pe_rst !== 1'b1) begin errors++; $display("FAIL reset_pe_rst: got %b required 1", pe_rst); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b required 0", done); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
        checks++; if (w_rd_en !== 1'b0) begin errors++; $display("FAIL reset_w_rd_en: got %b required 0", w_rd_en); end
        checks++; if (w_rd_addr !== '0 || out_addr !== '0) begin errors++; $display("FAIL reset_addrs: got %h/%h required 0/0", w_rd_addr, out_addr); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h required 0", out_data); end
        checks++; if (pe_vec_a !== '0 || pe_vec_b !== '0) begin errors++; $display("FAIL reset_pe_vecs: got nonzero operands, required 0"); end
        rst = 1'b0;
        brd = rd_cnt;
        repeat (20) step();
        checks++; if (rd_cnt != brd) begin errors++; $display("FAIL idle_no_read: got %0d reads required 0", rd_cnt - brd); end
        checks++; if (pe_rst !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL idle_state: got pe_rst=%b busy=%b required 1/0", pe_rst, busy); end
    endtask

    task automatic test_single_row();
        int lat; bit bok, to;
        int unsigned bw, br, bd, bwin, bdn;
        w_mem[0] = lanes(16'h0400);
        bw = wr_addr_q.size(); br = rd_cyc_q.size(); bd = done_cyc_q.size();
        bwin = rst_win_q.size(); bdn = done_cnt;
        run_job(1, lanes(16'h0800), 0, -1, lat, bok, to);
        checks++; if (to) begin errors++; $display("FAIL single_timeout: got no done, required done"); end
        checks++; if (wr_addr_q.size() != bw + 1) begin errors++; $display("FAIL single_writes: got %0d required 1", wr_addr_q.size() - bw); end
        checks++; if (wr_addr_q.size() <= bw || wr_addr_q[bw] !== 6'd0) begin errors++; $display("FAIL single_addr: got %h required 0", wr_addr_q[bw]); end
        checks++; if (wr_data_q.size() <= bw || wr_data_q[bw] !== 16'h4000) begin errors++; $display("FAIL single_data: got %h required 4000", wr_data_q[bw]); end
        checks++; if (done_cnt - bdn != 1) begin errors++; $display("FAIL single_done_count: got %0d required 1", done_cnt - bdn); end
        checks++; if (done_cyc_q.size() <= bd || rd_cyc_q.size() <= br || done_cyc_q[bd] - rd_cyc_q[br] != 22) begin
            errors++; $display("FAIL single_fetch_to_done: got %0d required 22", done_cyc_q[bd] - rd_cyc_q[br]); end
        checks++; if (rst_win_q.size() != bwin + 1) begin errors++; $display("FAIL single_pe_windows: got %0d required 1", rst_win_q.size() - bwin); end
        checks++; if (rst_win_q.size() <= bwin || rst_win_q[bwin] != 19) begin errors++; $display("FAIL single_run_len: got %0d required 19", rst_win_q[bwin]); end
        checks++; if (lat != 23) begin errors++; $display("FAIL single_latency: got %0d required 23", lat); end
        checks++; if (!bok) begin errors++; $display("FAIL single_busy: got busy drop or late clear, required high through DONE then low"); end
    endtask

    task automatic test_back_to_back_backpressure();
        int lat; bit bok, to;
        int unsigned bw, brd, bdn, bsv, briw;
        logic [255:0] vec;
        vec = lanes(16'h0800);
        for (int k = 0; k < 4; k++) w_mem[k] = lanes(16'(16'h0400 * (k + 1)));
        bw = wr_addr_q.size(); brd = rd_addr_q.size(); bdn = done_cnt;
        bsv = stall_viol; briw = rd_in_wr;
        run_job(4, vec, 5, -1, lat, bok, to);
        checks++; if (to) begin errors++; $display("FAIL multi_timeout: got no done, required done"); end
        checks++; if (wr_addr_q.size() != bw + 4) begin errors++; $display("FAIL multi_writes: got %0d required 4", wr_addr_q.size() - bw); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (rd_addr_q[brd + k] !== 6'(k)) begin errors++; $display("FAIL multi_rd_addr%0d: got %0d required %0d", k, rd_addr_q[brd + k], k); end
            checks++; if (wr_addr_q[bw + k] !== 6'(k)) begin errors++; $display("FAIL multi_wr_addr%0d: got %0d required %0d", k, wr_addr_q[bw + k], k); end
            checks++; if (wr_data_q[bw + k] !== ref_result(vec, w_mem[k])) begin
                errors++; $display("FAIL multi_data%0d: got %h required %h", k, wr_data_q[bw + k], ref_result(vec, w_mem[k])); end
        end
        checks++; if (stall_viol != bsv) begin errors++; $display("FAIL multi_stall_stable: got %0d changes required 0", stall_viol - bsv); end
        checks++; if (rd_in_wr != briw) begin errors++; $display("FAIL multi_read_in_write: got %0d required 0", rd_in_wr - briw); end
        checks++; if (done_cnt - bdn != 1) begin errors++; $display("FAIL multi_done_count: got %0d required 1", done_cnt - bdn); end
    endtask

    task automatic test_negative_zero();
        int lat; bit bok, to;
        int unsigned bw, brd, bdn, bv;
        logic [15:0] exp_neg;
`ifdef DOT_ROW_SCHED_RELU_EN
        exp_neg = 16'h0000;
`else
        exp_neg = 16'hC000;
`endif
        w_mem[0] = lanes(16'hFC00);
        bw = wr_data_q.size();
        run_job(1, lanes(16'h0800), 0, -1, lat, bok, to);
        checks++; if (to || wr_data_q.size() <= bw || wr_data_q[bw] !== exp_neg) begin
            errors++; $display("FAIL negative_data: got %h required %h", wr_data_q[bw], exp_neg); end
        bw = wr_data_q.size(); brd = rd_cnt; bdn = done_cnt; bv = valid_cnt;
        run_job(0, rand_vec(), 0, -1, lat, bok, to);
        checks++; if (lat != 1 || to) begin errors++; $display("FAIL zero_latency: got %0d required 1", lat); end
        checks++; if (rd_cnt != brd) begin errors++; $display("FAIL zero_reads: got %0d required 0", rd_cnt - brd); end
        checks++; if (valid_cnt != bv || wr_data_q.size() != bw) begin errors++; $display("FAIL zero_valid: got %0d valid cycles required 0", valid_cnt - bv); end
        checks++; if (done_cnt - bdn != 1) begin errors++; $display("FAIL zero_done: got %0d required 1", done_cnt - bdn); end
    endtask

    task automatic test_clamp_ignore();
        int lat; bit bok, to;
        int unsigned bw, brd, bdn;
        logic [255:0] vec;
        vec = rand_vec();
        for (int k = 0; k < 64; k++) w_mem[k] = rand_vec();
        bw = wr_addr_q.size(); brd = rd_cnt; bdn = done_cnt;
        run_job(100, vec, 0, 300, lat, bok, to);
        checks++; if (to) begin errors++; $display("FAIL clamp_timeout: got no done, required done"); end
        checks++; if (wr_addr_q.size() != bw + 64) begin errors++; $display("FAIL clamp_writes: got %0d required 64", wr_addr_q.size() - bw); end
        checks++; if (rd_cnt - brd != 64) begin errors++; $display("FAIL clamp_reads: got %0d required 64", rd_cnt - brd); end
        checks++; if (done_cnt - bdn != 1) begin errors++; $display("FAIL clamp_done: got %0d required 1", done_cnt - bdn); end
        for (int k = 0; k < 64 && bw + k < wr_addr_q.size(); k++) begin
            checks++; if (wr_addr_q[bw + k] !== 6'(k) || wr_data_q[bw + k] !== ref_result(vec, w_mem[k])) begin
                errors++; $display("FAIL clamp_row%0d: got %0d/%h required %0d/%h", k, wr_addr_q[bw + k],
                                   wr_data_q[bw + k], k, ref_result(vec, w_mem[k])); end
        end
    endtask

    task automatic test_reset_midrun();
        int lat; bit bok, to, hit;
        int unsigned brd, bdn, bw;
        logic [255:0] vec;
        vec = rand_vec();
        for (int k = 0; k < 4; k++) w_mem[k] = rand_vec();
        brd = rd_addr_q.size(); bdn = done_cnt;
        start = 1'b1; num_rows = 7'd4; in_vec = vec; out_ready = 1'b1;
        step();
        start = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (rd_addr_q.size() >= brd + 3) begin hit = 1'b1; break; end
            step();
        end
        checks++; if (!hit) begin errors++; $display("FAIL midrun_reach_row2: got no third fetch, required one"); end
        checks++; if (rd_addr_q.size() < brd + 3 || rd_addr_q[brd + 2] !== 6'd2) begin errors++; $display("FAIL midrun_row2_addr: got %0d required 2", rd_addr_q[brd + 2]); end
        repeat (3) step();
        checks++; if (pe_rst !== 1'b0) begin errors++; $display("FAIL midrun_in_run: got pe_rst=%b required 0", pe_rst); end
        rst = 1'b1;
        step();
        checks++; if (pe_rst !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL midrun_abort: got pe_rst=%b valid=%b busy=%b done=%b required 1/0/0/0", pe_rst, out_valid, busy, done); end
        checks++; if (out_data !== '0 || w_rd_addr !== '0) begin errors++; $display("FAIL midrun_regs: got %h/%h required 0/0", out_data, w_rd_addr); end
        rst = 1'b0;
        repeat (10) step();
        checks++; if (done_cnt != bdn || rd_addr_q.size() != brd + 3) begin
            errors++; $display("FAIL midrun_quiet: got done=%0d reads=%0d required 0/3", done_cnt - bdn, rd_addr_q.size() - brd); end
        bw = wr_addr_q.size();
        run_job(2, vec, 0, -1, lat, bok, to);
        checks++; if (to || wr_addr_q.size() != bw + 2) begin errors++; $display("FAIL rerun_writes: got %0d required 2", wr_addr_q.size() - bw); end
        for (int k = 0; k < 2 && bw + k < wr_addr_q.size(); k++) begin
            checks++; if (wr_addr_q[bw + k] !== 6'(k) || wr_data_q[bw + k] !== ref_result(vec, w_mem[k])) begin
                errors++; $display("FAIL rerun_row%0d: got %0d/%h required %0d/%h", k, wr_addr_q[bw + k],
                                   wr_data_q[bw + k], k, ref_result(vec, w_mem[k])); end
        end
    endtask

    task automatic test_random();
        int lat; bit bok, to;
        int unsigned bw, bsv;
        int n, stall;
        logic [255:0] vec;
        for (int it = 0; it < 4; it++) begin
            n = int'($urandom_range(1, 6));
            stall = int'($urandom_range(0, 3));
            vec = rand_vec();
            for (int k = 0; k < n; k++) w_mem[k] = rand_vec();
            bw = wr_addr_q.size(); bsv = stall_viol;
            run_job(n, vec, stall, -1, lat, bok, to);
            checks++; if (to || wr_addr_q.size() != bw + n) begin errors++; $display("FAIL rand%0d_writes: got %0d required %0d", it, wr_addr_q.size() - bw, n); end
            checks++; if (stall_viol != bsv) begin errors++; $display("FAIL rand%0d_stall: got %0d changes required 0", it, stall_viol - bsv); end
            for (int k = 0; k < n && bw + k < wr_addr_q.size(); k++) begin
                checks++; if (wr_addr_q[bw + k] !== 6'(k) || wr_data_q[bw + k] !== ref_result(vec, w_mem[k])) begin
                    errors++; $display("FAIL rand%0d_row%0d: got %0d/%h required %0d/%h", it, k, wr_addr_q[bw + k],
                                       wr_data_q[bw + k], k, ref_result(vec, w_mem[k])); end
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 64; k++) w_mem[k] = '0;
        test_reset();
        test_single_row();
        test_back_to_back_backpressure();
        test_negative_zero();
        test_clamp_ignore();
        test_reset_midrun();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
